uart_rx_datapath: RTL and testbench

Receive-side counterpart of the UART transmit datapath: it recovers frames from the serial `rx` line and presents received words to the UART core. The line passes through a two-flop synchronizer, and the block detects and revalidates the start bit. Each bit is sampled at mid-period using the CSR bit-period count, and the block checks parity and stop, then holds the word in a one-entry buffer with a valid/read handshake. The frame format matches the transmitter: start (0), data MSB-first (`data[N-1]` first), optional parity, stop (1).

---
 rtl/uart_rx_datapath.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_datapath.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: UART receive datapath.
// Synchronizes rx, detects and revalidates the start bit, samples each bit at
// mid-period from the bit-period count, checks parity and stop, and holds the
// received word in a one-entry buffer with a valid/read handshake.
// Frame: start(0), data MSB first, optional parity, stop(1).
// Optional feature: define UART_RX_MAJORITY_VOTE_EN for 2-of-3 sampling
// around each sample point (decision one cycle later, same targets).
module uart_rx_datapath #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [3:0]           data_bits,
    input  logic                 parity_en,
    input  logic                 odd_parity,
    input  logic                 rx_rd,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs, rxs_d1;
    logic [DIV_WIDTH-1:0]   bd_r, timer, target;
    logic [3:0]             nb_r, bit_cnt;
    logic                   pen_r, odd_r;
    logic [7:0]             sh;
    logic                   perr, ferr, done;
    logic                   cfg_ok, start_det, at_target;
    logic                   sample_now, bit_val;

    assign rxs = sync_q[SYNC_STAGES-1];

    // Configurations outside 5..8 data bits or below 4 clocks per bit are never started.
    assign cfg_ok    = (data_bits >= 4'd5) && (data_bits <= 4'd8) &&
                       (baud_div >= DIV_WIDTH'(4));
    assign start_det = (state == IDLE) && rxs_d1 && !rxs && cfg_ok;
    assign target    = (state == START) ? (bd_r >> 1) : (bd_r - DIV_WIDTH'(1));
    assign at_target = (state != IDLE) && (timer == target);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Voting decides one cycle after the target, so the timer restarts at 1
    // when leaving START to keep every later sample target where it was.
    localparam logic [DIV_WIDTH-1:0] TIMER_RESTART = DIV_WIDTH'(1);
    logic rxs_d2, pend;

    // Extra history tap and deferred-decision flag for the 2-of-3 vote.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxs_d2 <= 1'b1;
            pend   <= 1'b0;
        end else begin
            rxs_d2 <= rxs_d1;
            pend   <= at_target;
        end
    end

    assign sample_now = pend;
    assign bit_val    = (rxs_d2 & rxs_d1) | (rxs_d2 & rxs) | (rxs_d1 & rxs);
`else
    localparam logic [DIV_WIDTH-1:0] TIMER_RESTART = '0;
    assign sample_now = at_target;
    assign bit_val    = rxs;
`endif

    // Line synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            rxs_d1 <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_d1 <= rxs;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = START;
            START:   if (sample_now) state_nxt = bit_val ? IDLE : DATA;
            DATA:    if (sample_now && (bit_cnt == nb_r - 4'd1))
                         state_nxt = pen_r ? PARITY : STOP;
            PARITY:  if (sample_now) state_nxt = STOP;
            STOP:    if (sample_now) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Bit timer, config latch, shift register and per-frame error capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bd_r    <= '0;
            nb_r    <= '0;
            pen_r   <= 1'b0;
            odd_r   <= 1'b0;
            timer   <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (start_det) begin
                        bd_r    <= baud_div;
                        nb_r    <= data_bits;
                        pen_r   <= parity_en;
                        odd_r   <= odd_parity;
                        bit_cnt <= '0;
                        sh      <= '0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                    end
                end
                START: begin
                    if (sample_now && !bit_val) timer <= TIMER_RESTART;
                    else                        timer <= timer + DIV_WIDTH'(1);
                end
                default: begin
                    if (timer == bd_r - DIV_WIDTH'(1)) timer <= '0;
                    else                                timer <= timer + DIV_WIDTH'(1);
                end
            endcase
            if (sample_now) begin
                case (state)
                    DATA: begin
                        sh      <= {sh[6:0], bit_val};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    PARITY: perr <= (bit_val != ((^sh) ^ odd_r));
                    STOP: begin
                        ferr <= !bit_val;
                        done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // One-entry receive buffer: load on completion, drop with overrun when full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done && (!rx_valid || rx_rd)) begin
                rx_data    <= sh;
                parity_err <= perr;
                frame_err  <= ferr;
                rx_valid   <= 1'b1;
            end else if (done) begin
                overrun_err <= 1'b1;
            end else if (rx_rd && rx_valid) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Testbench for uart_rx_datapath: directed frames, a frame-level model of
// completions and the receive buffer checked every cycle, plus literal checks.
module tb_uart_rx_datapath;

    localparam int SYNC = 2;
    localparam int BD   = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, rx, parity_en, odd_parity, rx_rd;
    logic [31:0] baud_div;
    logic [3:0]  data_bits;
    logic [7:0]  rx_data;
    logic        rx_valid, parity_err, frame_err, overrun_err, busy;

    uart_rx_datapath #(.SYNC_STAGES(SYNC), .DIV_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .baud_div(baud_div),
        .data_bits(data_bits), .parity_en(parity_en), .odd_parity(odd_parity),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    ev_t        q[$];
    ev_t        ev;
    int         cyc, n_pass, n_tot, ovr_cnt, t_g, t_rd;
    bit         chk_en;
    logic       m_valid, m_perr, m_ferr, e_ovr, rd_s, rst_s;
    logic [7:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Start edge to rx_valid: sync + edge detect, half a bit, then N+P+1 bit periods.
    function automatic int lat(input int n, input int p);
        return SYNC + 3 + BD / 2 + (n + p + 1) * BD + VOTE;
    endfunction

    // Model: buffer behaviour driven by scheduled frame completions; compare each cycle.
    initial begin
        cyc = 0; ovr_cnt = 0;
        m_valid = 0; m_data = 0; m_perr = 0; m_ferr = 0; e_ovr = 0;
        forever begin
            @(posedge clk);
            cyc++;
            rd_s  = rx_rd;
            rst_s = rst_n;
            e_ovr = 0;
            if (!rst_s) begin
                m_valid = 0; m_data = 0; m_perr = 0; m_ferr = 0;
                q.delete();
            end else if (q.size() > 0 && q[0].t == cyc) begin
                ev = q.pop_front();
                if (!m_valid || rd_s) begin
                    m_valid = 1; m_data = ev.d; m_perr = ev.pe; m_ferr = ev.fe;
                end else begin
                    e_ovr = 1;
                end
            end else if (rd_s && m_valid) begin
                m_valid = 0; m_perr = 0; m_ferr = 0;
            end
            #1;
            if (overrun_err === 1'b1) ovr_cnt++;
            if (chk_en) begin
                n_tot++;
                if ({rx_valid, rx_data, parity_err, frame_err, overrun_err} ===
                    {m_valid, m_data, m_perr, m_ferr, e_ovr}) n_pass++;
                else $display("FAIL cycle_compare @%0d: got v=%b d=%h pe=%b fe=%b ov=%b expected v=%b d=%h pe=%b fe=%b ov=%b",
                              cyc, rx_valid, rx_data, parity_err, frame_err, overrun_err,
                              m_valid, m_data, m_perr, m_ferr, e_ovr);
            end
        end
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic rd_pulse();
        rx_rd = 1;
        @(posedge clk);
        #1;
        rx_rd = 0;
    endtask

    task automatic rd_at(input int t);
        while (cyc < t - 1) begin
            @(posedge clk);
            #1;
        end
        rd_pulse();
    endtask

    // Drive one frame at the bench bit period; schedule its completion if it should be received.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input bit exp);
        int         n, p;
        logic [7:0] dm;
        ev_t        e;
        n  = int'(data_bits);
        p  = parity_en ? 1 : 0;
        dm = d & 8'((1 << n) - 1);
        e.t  = cyc + lat(n, p);
        e.d  = dm;
        e.pe = parity_en && (pbit != ((^dm) ^ odd_parity));
        e.fe = !sbit;
        if (exp) q.push_back(e);
        drive_bit(1'b0);
        for (int i = n - 1; i >= 0; i--) drive_bit(dm[i]);
        if (parity_en) drive_bit(pbit);
        drive_bit(sbit);
        rx = 1;
    endtask

    initial begin
        n_pass = 0; n_tot = 0; chk_en = 0;
        rst_n = 0; rx = 1; rx_rd = 0; baud_div = BD;
        data_bits = 8; parity_en = 0; odd_parity = 0;
        idle(4);
        rst_n = 1;
        chk_en = 1;
        check("reset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun_err, busy}, 0);
        idle(5);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        idle(2);
        check("a5_data", rx_data, 8'hA5);
        check("a5_flags", {rx_valid, parity_err, frame_err}, 3'b100);
        rd_pulse();
        idle(1);
        check("a5_read_clears", rx_valid, 0);

        // 7O1 0x35: four ones, so odd parity needs a 1; a 0 is the wrong bit.
        data_bits = 7; parity_en = 1; odd_parity = 1;
        send_frame(8'h35, 1'b0, 1'b1, 1);
        idle(2);
        check("par_bad_data", rx_data, 8'h35);
        check("par_bad_perr", parity_err, 1);
        rd_pulse();
        send_frame(8'h35, 1'b1, 1'b1, 1);
        idle(2);
        check("par_good_flags", {rx_valid, parity_err}, 2'b10);
        rd_pulse();

        // 5N1 0x13 with stop bit low
        data_bits = 5; parity_en = 0; odd_parity = 0;
        send_frame(8'h13, 1'b0, 1'b0, 1);
        idle(BD);
        check("ferr_data", rx_data, 8'h13);
        check("ferr_flag", frame_err, 1);
        rd_pulse();
        idle(1);
        check("ferr_cleared", {rx_valid, frame_err}, 0);

        // 3-cycle glitch: false start rejected at the half-bit sample
        data_bits = 8;
        idle(4);
        rx = 0; t_g = cyc;
        idle(3);
        rx = 1;
        idle(2);
        check("glitch_busy_high", busy, 1);
        idle(13);
        check("glitch_busy_low", {busy, rx_valid}, 0);

        // Ignored configurations
        data_bits = 4;
        fork
            send_frame(8'h0F, 1'b0, 1'b1, 0);
            begin idle(2 * BD); check("badbits_busy", busy, 0); end
        join
        data_bits = 8; baud_div = 3;
        fork
            send_frame(8'h55, 1'b0, 1'b1, 0);
            begin idle(3 * BD); check("baddiv_busy", busy, 0); end
        join
        baud_div = BD;
        idle(4);
        check("badcfg_novalid", rx_valid, 0);

        // Overrun: second word dropped, first kept
        send_frame(8'h11, 1'b0, 1'b1, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1);
        idle(2);
        check("ovr_keep_data", rx_data, 8'h11);
        check("ovr_pulse_count", ovr_cnt, 1);
        rd_pulse();
        idle(2);

        // Read on the second completion cycle takes the new word
        send_frame(8'h11, 1'b0, 1'b1, 1);
        t_rd = cyc + lat(8, 0);
        fork
            send_frame(8'h22, 1'b0, 1'b1, 1);
            rd_at(t_rd);
        join
        idle(2);
        check("rd_on_done_data", {rx_valid, rx_data}, 9'h122);
        check("rd_on_done_no_ovr", ovr_cnt, 1);

        // Reset in the middle of DATA, word 0x22 still held
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("mid_frame_busy", busy, 1);
        rx = 1; rst_n = 0;
        idle(2);
        rst_n = 1;
        idle(1);
        check("mid_reset_outputs", {rx_data, rx_valid, parity_err, frame_err, overrun_err, busy}, 0);
        idle(5);
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        idle(2);
        check("after_reset_data", {rx_valid, rx_data}, 9'h15A);
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
